// File: rtl/jk_arb_pkg.sv
// jk_arb_pkg: op encodings and FSM state type shared by the JK flip-flop arbiter.
package jk_arb_pkg;
  localparam logic [1:0] OP_HOLD = 2'b00;
  localparam logic [1:0] OP_RST  = 2'b01;
  localparam logic [1:0] OP_SET  = 2'b10;
  localparam logic [1:0] OP_TGL  = 2'b11;
  typedef enum logic [1:0] {IDLE, APPLY, ACK} state_e;
endpackage

// File: rtl/jk_ff_cell.sv
// jk_ff_cell: enable-gated JK flip-flop with asynchronous active-low clear.
module jk_ff_cell (
  input  logic eneable,
  input  logic reset,
  input  logic clk,
  input  logic J,
  input  logic K,
  output logic Q
);
  always_ff @(posedge clk or negedge reset)
    if (!reset) Q <= 1'b0;
    else if (eneable) Q <= (J && K) ? ~Q : J ? 1'b1 : K ? 1'b0 : Q;
endmodule

// File: rtl/jk_ff_arbiter.sv
// jk_ff_arbiter: arbitrates requester ops onto one shared JK cell (IDLE/APPLY/ACK).
// Define JK_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module jk_ff_arbiter
  import jk_arb_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [2*NREQ-1:0] op,
  output logic [NREQ-1:0]   gnt,
  output logic              busy,
  output logic              q
);
  localparam int IW = $clog2(NREQ);
  state_e        state_q;
  logic [IW-1:0] idx_q, win_d;
  logic [1:0]    op_q;
`ifndef JK_ARB_FIXED_PRIO_EN
  logic [IW-1:0] ptr_q;
`endif
  always_comb begin
    win_d = '0;
    // Scan from the far end down so the first high bit in search order wins.
    for (int k = NREQ - 1; k >= 0; k--) begin
`ifdef JK_ARB_FIXED_PRIO_EN
      if (req[k]) win_d = IW'(k);
`else
      int j;
      j = int'(ptr_q) + k;
      if (j >= NREQ) j -= NREQ;
      if (req[j]) win_d = IW'(j);
`endif
    end
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      op_q    <= OP_HOLD;
`ifndef JK_ARB_FIXED_PRIO_EN
      ptr_q   <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: if (|req) begin
          idx_q   <= win_d;
          op_q    <= op[2*win_d +: 2];
          state_q <= APPLY;
        end
        APPLY: state_q <= ACK;
        default: begin
          state_q <= IDLE;
`ifndef JK_ARB_FIXED_PRIO_EN
          ptr_q   <= (int'(idx_q) == NREQ - 1) ? '0 : idx_q + 1'b1;
`endif
        end
      endcase
    end
  assign gnt  = (state_q == ACK) ? (NREQ'(1) << idx_q) : '0;
  assign busy = state_q != IDLE;
  jk_ff_cell u_cell (
    .eneable(state_q == APPLY),
    .reset  (reset),
    .clk    (clk),
    .J      (op_q[1]),
    .K      (op_q[0]),
    .Q      (q)
  );
endmodule
